// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer for the Execute stage.
//
// Takes one M-type operation from the pipeline and runs it in a 32-step loop
// (radix-2 shift-add for multiply, restoring subtract for divide). It stalls
// the pipeline until the result is ready. Divide-by-zero and signed-divide
// overflow finish in a single cycle.
//
// Ports:
//   clk     - clock, rising edge
//   clr     - asynchronous active-high reset
//   start   - M-type instruction present in E (held high while stalled)
//   funct3  - op select: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   a, b    - rs1 / rs2 operands after forwarding
//   flush   - synchronous abort of the current operation
//   stall   - combinational pipeline stall request
//   busy    - sequencer is not idle
//   done    - one-cycle result-valid pulse
//   result  - registered result, held after done
module muldiv_seq #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic                rneg_q, rneg_d;
    logic [XLEN-1:0]     dvs_q, dvs_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN:0]       rem_q, rem_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Operand decode for the incoming instruction.
    logic            is_div_in, a_signed_in, b_signed_in, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag, special_res;
    logic            div_by_zero, div_ovf;

    // One loop step, shared by both operation kinds.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, prod_fin;
    logic [XLEN:0]     shifted, rem_next;
    logic              ge;
    logic [XLEN-1:0]   quo_next, quo_fin, rem_fin, final_res;

    // Sign handling: a is signed for MULH/MULHSU/DIV/REM, b for MULH/DIV/REM.
    // Multiplier and dividend both start in the low half of acc, so the
    // launch path is the same for every operation.
    always_comb begin
        is_div_in   = funct3[2];
        a_signed_in = is_div_in ? ~funct3[0] : (funct3[1] ^ funct3[0]);
        b_signed_in = is_div_in ? ~funct3[0] : (funct3[1:0] == 2'b01);
        a_neg       = a_signed_in & a[XLEN-1];
        b_neg       = b_signed_in & b[XLEN-1];
        a_mag       = a_neg ? -a : a;
        b_mag       = b_neg ? -b : b;
        div_by_zero = is_div_in & (b == '0);
        div_ovf     = is_div_in & ~funct3[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
        if (div_by_zero) begin
            special_res = funct3[1] ? a : '1;
        end else begin
            special_res = funct3[1] ? '0 : a;
        end
    end

    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the 65-bit sum right.
    // Divide: shift the next dividend bit into the partial remainder and
    // subtract the divisor when it fits. The remainder's top bit is always 0
    // between steps; it is folded into the compare so no bit goes unused.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        prod_fin = neg_q ? -mul_next : mul_next;

        shifted  = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
        ge       = rem_q[XLEN] | (shifted >= {1'b0, dvs_q});
        rem_next = ge ? (shifted - {1'b0, dvs_q}) : shifted;
        quo_next = {acc_q[XLEN-2:0], ge};
        quo_fin  = neg_q ? -quo_next : quo_next;
        rem_fin  = rneg_q ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];

        if (op_q[2]) begin
            final_res = op_q[1] ? rem_fin : quo_fin;
        end else begin
            final_res = (op_q[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic. Flush overrides everything except clr; it drops back
    // to IDLE and leaves the previous result visible.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dvs_d    = dvs_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;

        if (flush) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_d    = funct3;
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        dvs_d   = b_mag;
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        rem_d   = '0;
                        count_d = '0;
                        if (div_by_zero | div_ovf) begin
                            result_d = special_res;
                            state_d  = DONE;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        acc_d = {acc_q[2*XLEN-1:XLEN], quo_next};
                        rem_d = rem_next;
                    end else begin
                        acc_d = mul_next;
                    end
                    if (count_q == LAST) begin
                        result_d = final_res;
                        count_d  = '0;
                        state_d  = DONE;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dvs_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dvs_q    <= dvs_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    // clr gates stall so a held start cannot keep the pipeline frozen
    // while the sequencer is being reset.
    assign stall  = ~clr & (((state_q == IDLE) & start & ~flush) | (state_q == CALC));
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule
